// File: rtl/seg7_reader.sv
// seg7_reader: recovers the hex digits shown on an external multiplexed,
// common-anode, active-low 7-segment display bus.
//
// The anode selects and segment lines are synchronised (2 flops each). Each
// digit's pattern is debounced by a stability counter and decoded into a
// shadow frame. Once every digit position has been captured, the frame is
// offered on a valid/ready handshake.
//
// Optional feature: define SEG7RD_DP_EN to also sample the decimal point
// (dp input, active-low) and report it per digit on dp_out.
//
// Ports:
//   clk    rising-edge system clock
//   rst    synchronous active-high reset
//   en     capture enable; 0 aborts the frame in progress
//   an     digit selects, active-low, asynchronous
//   seg    segment lines gfedcba, active-low, asynchronous
//   dp     decimal point, active-low (SEG7RD_DP_EN only)
//   value  captured digits, an[i] -> value[4i+3:4i]
//   blank  1 = digit i had all segments off
//   err    1 = digit i showed an unrecognised pattern
//   dp_out 1 = decimal point of digit i lit (SEG7RD_DP_EN only)
//   valid  frame available
//   ready  consumer accepts frame
module seg7_reader #(
    parameter int NDIG   = 4,
    parameter int STABLE = 8,
    parameter int CW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NDIG-1:0]   an,
    input  logic [6:0]        seg,
`ifdef SEG7RD_DP_EN
    input  logic              dp,
    output logic [NDIG-1:0]   dp_out,
`endif
    output logic [4*NDIG-1:0] value,
    output logic [NDIG-1:0]   blank,
    output logic [NDIG-1:0]   err,
    output logic              valid,
    input  logic              ready
);

    // Returns {err, blank, code}.
    function automatic logic [5:0] decode(input logic [6:0] s);
        logic [5:0] r;
        case (s)
            7'b1000000: r = 6'h00;
            7'b1111001: r = 6'h01;
            7'b0100100: r = 6'h02;
            7'b0110000: r = 6'h03;
            7'b0011001: r = 6'h04;
            7'b0010010: r = 6'h05;
            7'b0000010: r = 6'h06;
            7'b1111000: r = 6'h07;
            7'b0000000: r = 6'h08;
            7'b0011000: r = 6'h09;
            7'b0010000: r = 6'h09;
            7'b0001000: r = 6'h0A;
            7'b0000011: r = 6'h0B;
            7'b1000110: r = 6'h0C;
            7'b0100001: r = 6'h0D;
            7'b0000110: r = 6'h0E;
            7'b0001110: r = 6'h0F;
            7'b1111111: r = 6'b010000;
            default:    r = 6'b100000;
        endcase
        return r;
    endfunction

    // Synchronisers (m = metastable stage, s = synchronised) and the
    // previous synchronised sample used for the stability compare.
    logic [NDIG-1:0] an_m_q, an_s_q, an_p_q;
    logic [6:0]      seg_m_q, seg_s_q, seg_p_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NDIG-1:0] seen_q, seen_d;
    logic            valid_q;
    logic            same, active, cap, load;
    logic [NDIG-1:0] an_inv, cap_vec;
    logic [5:0]      dec;

`ifdef SEG7RD_DP_EN
    logic dp_m_q, dp_s_q, dp_p_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_m_q <= 1'b1;
            dp_s_q <= 1'b1;
            dp_p_q <= 1'b1;
        end else begin
            dp_m_q <= dp;
            dp_s_q <= dp_m_q;
            dp_p_q <= dp_s_q;
        end
    end
    assign same = (an_s_q == an_p_q) && (seg_s_q == seg_p_q) && (dp_s_q == dp_p_q);
`else
    assign same = (an_s_q == an_p_q) && (seg_s_q == seg_p_q);
`endif

    // Active means exactly one select low: the inverted vector is one-hot.
    assign an_inv = ~an_s_q;
    assign active = (an_inv != '0) && ((an_inv & (an_inv - NDIG'(1))) == '0);

    // Capture on the edge where the counter reaches STABLE-1; the counter
    // then saturates, so a visit captures only once until the pair changes.
    assign cap  = en && active && same && (cnt_q == CW'(STABLE - 2));
    assign load = (&seen_q) && (!valid_q || ready);
    assign dec  = decode(seg_s_q);

    always_comb begin
        cnt_d = cnt_q;
        if (!en || !active || !same)
            cnt_d = '0;
        else if (cnt_q != CW'(STABLE - 1))
            cnt_d = cnt_q + CW'(1);

        seen_d = (load ? '0 : seen_q) | cap_vec;
        if (!en)
            seen_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_m_q  <= '1;
            an_s_q  <= '1;
            an_p_q  <= '1;
            seg_m_q <= '1;
            seg_s_q <= '1;
            seg_p_q <= '1;
            cnt_q   <= '0;
            seen_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            an_m_q  <= an;
            an_s_q  <= an_m_q;
            an_p_q  <= an_s_q;
            seg_m_q <= seg;
            seg_s_q <= seg_m_q;
            seg_p_q <= seg_s_q;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            if (load)
                valid_q <= 1'b1;
            else if (ready)
                valid_q <= 1'b0;
        end
    end

    // Per-slot shadow frame and output registers.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_slot
        logic [3:0] shadow_q, value_q;
        logic       sblank_q, serr_q, blank_q, err_q;

        assign cap_vec[gi] = cap && !an_s_q[gi];

        always_ff @(posedge clk) begin
            if (rst) begin
                shadow_q <= '0;
                sblank_q <= 1'b0;
                serr_q   <= 1'b0;
                value_q  <= '0;
                blank_q  <= 1'b0;
                err_q    <= 1'b0;
            end else begin
                if (cap_vec[gi]) begin
                    shadow_q <= dec[3:0];
                    sblank_q <= dec[4];
                    serr_q   <= dec[5];
                end
                if (load) begin
                    value_q <= shadow_q;
                    blank_q <= sblank_q;
                    err_q   <= serr_q;
                end
            end
        end

        assign value[4*gi +: 4] = value_q;
        assign blank[gi]        = blank_q;
        assign err[gi]          = err_q;

`ifdef SEG7RD_DP_EN
        logic sdp_q, dp_out_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                sdp_q    <= 1'b0;
                dp_out_q <= 1'b0;
            end else begin
                if (cap_vec[gi])
                    sdp_q <= ~dp_s_q;
                if (load)
                    dp_out_q <= sdp_q;
            end
        end
        assign dp_out[gi] = dp_out_q;
`endif
    end

    assign valid = valid_q;

endmodule

// File: tb/tb_seg7_reader.sv
module tb_seg7_reader;
    localparam int NDIG   = 4;
    localparam int STABLE = 8;
    localparam int CW     = 4;

    logic        clk = 1'b0;
    logic        rst, en, ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] value;
    logic [3:0]  blank, err;
    logic        valid;
`ifdef SEG7RD_DP_EN
    logic        dp = 1'b1;
    logic [3:0]  dp_out;
`endif

    seg7_reader #(.NDIG(NDIG), .STABLE(STABLE), .CW(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .an(an), .seg(seg),
`ifdef SEG7RD_DP_EN
        .dp(dp), .dp_out(dp_out),
`endif
        .value(value), .blank(blank), .err(err), .valid(valid), .ready(ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int vcycles = 0;

    // Reference model: digit glyph table and the frame currently being built.
    logic [6:0]  pat_tab [16];
    logic [3:0]  m_val   [NDIG];
    logic        m_blank [NDIG];
    logic        m_err   [NDIG];
    bit          m_seen  [NDIG];
    logic [23:0] exp_q[$];
    logic [23:0] act_q[$];

    // Every completed handshake is one consumed frame.
    always @(negedge clk) begin
        if (valid) vcycles++;
        if (valid && ready) act_q.push_back({err, blank, value});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void model_decode(input logic [6:0] p, output logic [3:0] c,
                                         output logic b, output logic e);
        c = 4'h0; b = 1'b0; e = 1'b0;
        if (p == 7'h7F) b = 1'b1;
        else begin
            e = 1'b1;
            for (int i = 0; i < 16; i++)
                if (p == pat_tab[i]) begin c = 4'(i); e = 1'b0; end
            if (p == 7'b0010000) begin c = 4'h9; e = 1'b0; end
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NDIG; i++) begin
            m_val[i] = 4'h0; m_blank[i] = 1'b0; m_err[i] = 1'b0; m_seen[i] = 1'b0;
        end
    endtask

    // Show pattern p on digit d for cyc cycles, then gap cycles with no digit.
    task automatic visit(input int d, input logic [6:0] p, input int cyc, input int gap);
        logic [3:0] c;
        logic b, e;
        bit all;
        logic [23:0] f;
        an  = ~(4'b0001 << d);
        seg = p;
        tick(cyc);
        an  = 4'hF;
        seg = 7'h7F;
        if (gap > 0) tick(gap);
        if (cyc >= STABLE + 3 && en) begin
            model_decode(p, c, b, e);
            m_val[d] = c; m_blank[d] = b; m_err[d] = e; m_seen[d] = 1'b1;
            all = 1'b1;
            for (int i = 0; i < NDIG; i++) all = all && m_seen[i];
            if (all) begin
                for (int i = 0; i < NDIG; i++) begin
                    f[4*i +: 4] = m_val[i];
                    f[16 + i]   = m_blank[i];
                    f[20 + i]   = m_err[i];
                    m_seen[i]   = 1'b0;
                end
                exp_q.push_back(f);
            end
        end
    endtask

    task automatic check_frames(input string tag);
        logic [23:0] a, x;
        check({tag, "_count"}, act_q.size(), exp_q.size());
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front();
            x = exp_q.pop_front();
            check({tag, "_frame"}, a, x);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic show_frame(input logic [15:0] h);
        for (int i = 0; i < NDIG; i++) visit(i, pat_tab[h[4*i +: 4]], 20, 0);
    endtask

    function automatic logic [6:0] rand_pat();
        int r;
        logic [6:0] p;
        logic [3:0] c;
        logic b, e;
        r = $urandom_range(0, 17);
        if (r < 16) begin
            p = pat_tab[r];
            if (r == 9 && $urandom_range(0, 1) == 1) p = 7'b0010000;
        end else if (r == 16) begin
            p = 7'h7F;
        end else begin
            do begin
                p = 7'($urandom_range(0, 127));
                model_decode(p, c, b, e);
            end while (!e);
        end
        return p;
    endfunction

    initial begin
        int v0;
        int perm[4];
        int j, t;

        pat_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        model_reset();

        // Reset with a gap pattern (all selects low) on the pins.
        rst = 1'b1; en = 1'b1; ready = 1'b1; an = 4'h0; seg = 7'h00;
        tick(3);
        check("rst_value", value, 16'h0);
        check("rst_blank", blank, 4'h0);
        check("rst_err",   err,   4'h0);
        check("rst_valid", valid, 1'b0);
        rst = 1'b0;
        an = 4'hF; seg = 7'h7F;
        tick(1);
        check("post_rst_valid", valid, 1'b0);

        // Basic frame: 4321 with ready held high, valid should pulse once.
        v0 = vcycles;
        show_frame(16'h4321);
        tick(4);
        check_frames("basic");
        check("basic_value", value, 16'h4321);
        check("basic_pulse", vcycles - v0, 1);

        // Glitch rejection: a short 8 before the real A on digit 0.
        visit(0, 7'b0000000, 5, 0);
        visit(0, 7'b0001000, 20, 2);
        for (int i = 1; i < NDIG; i++) visit(i, 7'b0000000, 20, 2);
        tick(4);
        check_frames("glitch");
        check("glitch_d0", value[3:0], 4'hA);

        // Blank on digit 1, unrecognised pattern on digit 2.
        visit(0, pat_tab[5], 20, 0);
        visit(1, 7'b1111111, 20, 0);
        visit(2, 7'b0101010, 20, 0);
        visit(3, pat_tab[9], 20, 0);
        tick(4);
        check_frames("blankerr");
        check("be_blank", blank, 4'b0010);
        check("be_err",   err,   4'b0100);
        check("be_value", value, 16'h9005);

        // Backpressure: two frames complete while ready is low.
        ready = 1'b0;
        show_frame(16'h1234);
        tick(4);
        check("bp1_valid", valid, 1'b1);
        check("bp1_value", value, 16'h1234);
        show_frame(16'h5678);
        tick(4);
        check("bp2_valid", valid, 1'b1);
        check("bp2_value", value, 16'h1234);
        ready = 1'b1; tick(1); ready = 1'b0;
        check("bp3_valid", valid, 1'b1);
        check("bp3_value", value, 16'h5678);
        tick(3);
        check("bp4_value", value, 16'h5678);
        ready = 1'b1; tick(1); ready = 1'b0;
        check("bp5_valid", valid, 1'b0);
        check_frames("bp");
        ready = 1'b1;

        // Enable abort: digits 0-1 captured then discarded by en=0.
        v0 = vcycles;
        visit(0, pat_tab[7], 20, 2);
        visit(1, pat_tab[8], 20, 2);
        en = 1'b0;
        tick(3);
        for (int i = 0; i < NDIG; i++) m_seen[i] = 1'b0;
        en = 1'b1;
        visit(2, pat_tab[12], 20, 2);
        visit(3, pat_tab[13], 20, 2);
        tick(4);
        check("abort_valid", valid, 1'b0);
        check("abort_nopulse", vcycles - v0, 0);
        check_frames("abort_none");
        visit(0, pat_tab[14], 20, 2);
        visit(1, pat_tab[15], 20, 2);
        tick(4);
        check_frames("abort_done");
        check("abort_value", value, 16'hDCFE);

        // Randomised frames with glitches and slot overwrites.
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < 4; i++) perm[i] = i;
            for (int i = 3; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0)
                    visit($urandom_range(0, 3), rand_pat(), $urandom_range(1, STABLE - 1), 2);
                if (i == 3 && $urandom_range(0, 2) == 0)
                    visit(perm[0], rand_pat(), $urandom_range(STABLE + 3, 24), 2);
                visit(perm[i], rand_pat(), $urandom_range(STABLE + 3, 24), 2);
            end
            tick(4);
            check_frames("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
